// File: rtl/test_level_sequencer_if.sv
// Request/stimulus bundle between the mode logic and the CDU test-level sequencer.
// The mode logic is the master; the sequencer is the slave.
interface test_level_sequencer_if;
  logic       ZREQ;
  logic       C1REQ;
  logic       F1REQ;
  logic       F2REQ;
  logic       ABORT;
  logic       CCDUZ;
  logic       ATLC1H;
  logic       ATLF1H;
  logic       ATLF2H;
  logic       BUSY;
  logic       DONE;
  logic [3:0] PEND;

  modport master (
    output ZREQ, C1REQ, F1REQ, F2REQ, ABORT,
    input  CCDUZ, ATLC1H, ATLF1H, ATLF2H, BUSY, DONE, PEND
  );

  modport slave (
    input  ZREQ, C1REQ, F1REQ, F2REQ, ABORT,
    output CCDUZ, ATLC1H, ATLF1H, ATLF2H, BUSY, DONE, PEND
  );
endinterface

// File: rtl/test_level_sequencer.sv
// Queues CDU zero / self-test requests and runs them one at a time by fixed priority,
// producing the CCDUZ pulse or a low-first square-wave test level.
//
// state  | meaning
// IDLE   | no run active; grants the highest-priority pending request
// ZERO   | CCDUZ held high for ZERO_CYCLES cycles
// COARSE | ATLC1H square wave, N_CYCLES periods
// FINE1  | ATLF1H square wave, N_CYCLES periods
// FINE2  | ATLF2H square wave, N_CYCLES periods
module test_level_sequencer #(
  parameter int HALF_PERIOD = 640,
  parameter int N_CYCLES    = 4,
  parameter int ZERO_CYCLES = 16
) (
  input  logic                 CLOCKH,
  input  logic                 rst,
  test_level_sequencer_if.slave bus
);
  localparam int HW = $clog2(HALF_PERIOD);
  localparam int PW = $clog2(N_CYCLES + 1);
  localparam int ZW = $clog2(ZERO_CYCLES + 1);
  localparam logic [HW-1:0] HALF_LAST = HW'(HALF_PERIOD - 1);
  localparam logic [PW-1:0] PER_LAST  = PW'(N_CYCLES - 1);
  localparam logic [ZW-1:0] ZERO_LAST = ZW'(ZERO_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, ZERO, COARSE, FINE1, FINE2} state_t;

  state_t        state;
  logic [HW-1:0] half_cnt;
  logic          phase;
  logic [PW-1:0] per_cnt;
  logic [ZW-1:0] zero_cnt;
  logic [3:0]    pend;
  logic [3:0]    req;
  logic [3:0]    grant;
  logic          ccduz, atlc1h, atlf1h, atlf2h, busy, done;

  // Lowest set bit of pend is the highest-priority request (Z first).
  always_comb begin
    req   = {bus.F2REQ, bus.F1REQ, bus.C1REQ, bus.ZREQ};
    grant = pend & (~pend + 4'd1);
  end

  always_ff @(posedge CLOCKH or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      half_cnt <= '0;
      phase    <= 1'b0;
      per_cnt  <= '0;
      zero_cnt <= '0;
      pend     <= '0;
      ccduz    <= 1'b0;
      atlc1h   <= 1'b0;
      atlf1h   <= 1'b0;
      atlf2h   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else if (bus.ABORT) begin
      state    <= IDLE;
      half_cnt <= '0;
      phase    <= 1'b0;
      per_cnt  <= '0;
      zero_cnt <= '0;
      pend     <= '0;
      ccduz    <= 1'b0;
      atlc1h   <= 1'b0;
      atlf1h   <= 1'b0;
      atlf2h   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      pend <= (state == IDLE) ? ((pend & ~grant) | req) : (pend | req);
      case (state)
        IDLE: begin
          half_cnt <= '0;
          phase    <= 1'b0;
          per_cnt  <= '0;
          zero_cnt <= '0;
          if (grant != 4'd0) begin
            busy  <= 1'b1;
            ccduz <= grant[0];
            if (grant[0])      state <= ZERO;
            else if (grant[1]) state <= COARSE;
            else if (grant[2]) state <= FINE1;
            else               state <= FINE2;
          end
        end
        ZERO: begin
          if (zero_cnt == ZERO_LAST) begin
            state <= IDLE;
            ccduz <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            zero_cnt <= zero_cnt + ZW'(1);
          end
        end
        default: begin
          if (half_cnt != HALF_LAST) begin
            half_cnt <= half_cnt + HW'(1);
          end else begin
            half_cnt <= '0;
            if (!phase) begin
              phase  <= 1'b1;
              atlc1h <= (state == COARSE);
              atlf1h <= (state == FINE1);
              atlf2h <= (state == FINE2);
            end else begin
              // High-to-low wrap: either another period or the end of the run.
              atlc1h <= 1'b0;
              atlf1h <= 1'b0;
              atlf2h <= 1'b0;
              phase  <= 1'b0;
              if (per_cnt == PER_LAST) begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                per_cnt <= per_cnt + PW'(1);
              end
            end
          end
        end
      endcase
    end
  end

  assign bus.CCDUZ  = ccduz;
  assign bus.ATLC1H = atlc1h;
  assign bus.ATLF1H = atlf1h;
  assign bus.ATLF2H = atlf2h;
  assign bus.BUSY   = busy;
  assign bus.DONE   = done;
  assign bus.PEND   = pend;
endmodule

// File: tb/tb_test_level_sequencer.sv
// Self-checking bench for test_level_sequencer: directed sequences, a vector table,
// and random requests compared every cycle against a run-index reference model.
module tb_test_level_sequencer;
  localparam int H = 4;
  localparam int N = 2;
  localparam int Z = 3;

  logic CLOCKH = 1'b0;
  logic rst    = 1'b1;
  int   checks = 0;
  int   errors = 0;

  test_level_sequencer_if bus ();
  test_level_sequencer_if bus_d ();

  test_level_sequencer #(.HALF_PERIOD(H), .N_CYCLES(N), .ZERO_CYCLES(Z)) dut (
    .CLOCKH(CLOCKH), .rst(rst), .bus(bus)
  );
  test_level_sequencer dut_d (
    .CLOCKH(CLOCKH), .rst(rst), .bus(bus_d)
  );

  always #5 CLOCKH = ~CLOCKH;

  // Reference model: run kind (-1 idle, 0 Z, 1 C1, 2 F1, 3 F2) and cycle index within the run.
  int       m_kind = -1;
  int       m_t    = 0;
  bit [3:0] m_pend = '0;
  bit       m_done = 1'b0;

  function automatic int run_len(input int k);
    return (k == 0) ? Z : 2 * H * N;
  endfunction

  task automatic model_reset();
    m_kind = -1;
    m_t    = 0;
    m_pend = '0;
    m_done = 1'b0;
  endtask

  task automatic model_edge(input bit [3:0] rq, input bit ab);
    bit [3:0] old;
    bit [3:0] g;
    int       sel;
    old = m_pend;
    g   = '0;
    if (ab) begin
      model_reset();
    end else begin
      m_done = 1'b0;
      if (m_kind < 0) begin
        if (old != 4'd0) begin
          sel = 0;
          for (int i = 3; i >= 0; i--) if (old[i]) sel = i;
          g[sel] = 1'b1;
          m_kind = sel;
          m_t    = 0;
        end
      end else begin
        m_t++;
        if (m_t == run_len(m_kind)) begin
          m_kind = -1;
          m_done = 1'b1;
        end
      end
      m_pend = (old & ~g) | rq;
    end
  endtask

  function automatic logic [9:0] m_vec();
    bit hi;
    hi = (m_kind > 0) && (((m_t / H) % 2) == 1);
    return {m_kind == 0, hi && m_kind == 1, hi && m_kind == 2, hi && m_kind == 3,
            m_kind >= 0, m_done, m_pend};
  endfunction

  function automatic logic [9:0] dut_vec();
    return {bus.CCDUZ, bus.ATLC1H, bus.ATLF1H, bus.ATLF2H, bus.BUSY, bus.DONE, bus.PEND};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] v);
    {bus.ABORT, bus.F2REQ, bus.F1REQ, bus.C1REQ, bus.ZREQ} = v;
  endtask

  task automatic step();
    @(posedge CLOCKH);
    if (rst) model_reset();
    else model_edge({bus.F2REQ, bus.F1REQ, bus.C1REQ, bus.ZREQ}, bus.ABORT);
    #1;
    chk("model", {22'd0, dut_vec()}, {22'd0, m_vec()});
  endtask

  task automatic pulse(input logic [4:0] v);
    drive(v);
    step();
    drive(5'd0);
  endtask

  typedef struct {
    logic [4:0] in;
    logic [9:0] exp;
  } vec_t;
  vec_t tbl[11];

  initial begin
    logic [19:0] pat_f1;
    int nruns, cur, last_done, nz, done_n, rises, first_rise;
    int plog[4];
    int rlen[4];
    bit prev_busy, prev_lvl;
    int exp_pend[4];
    int exp_len[4];

    // Abort table: {ABORT,F2,F1,C1,Z} -> {CCDUZ,C1,F1,F2,BUSY,DONE,PEND}
    tbl[0]  = '{5'b01000, 10'b0000_00_1000};
    tbl[1]  = '{5'b00000, 10'b0000_10_0000};
    tbl[2]  = '{5'b00000, 10'b0000_10_0000};
    tbl[3]  = '{5'b00000, 10'b0000_10_0000};
    tbl[4]  = '{5'b00000, 10'b0000_10_0000};
    tbl[5]  = '{5'b00000, 10'b0001_10_0000};
    tbl[6]  = '{5'b00000, 10'b0001_10_0000};
    tbl[7]  = '{5'b10100, 10'b0000_00_0000};
    tbl[8]  = '{5'b00000, 10'b0000_00_0000};
    tbl[9]  = '{5'b00000, 10'b0000_00_0000};
    tbl[10] = '{5'b00000, 10'b0000_00_0000};

    drive(5'd0);
    {bus_d.ABORT, bus_d.F2REQ, bus_d.F1REQ, bus_d.C1REQ, bus_d.ZREQ} = 5'd0;
    model_reset();
    repeat (2) step();
    rst = 1'b0;
    chk("reset_vec", {22'd0, dut_vec()}, 32'd0);
    chk("reset_busy_d", {31'd0, bus_d.BUSY}, 32'd0);

    // Single fine-1 run
    pat_f1 = 20'b0000_1111_0000_1111_0000;
    pulse(5'b00100);
    for (int c = 1; c <= 20; c++) begin
      step();
      chk("f1_level", {31'd0, bus.ATLF1H}, {31'd0, pat_f1[20-c]});
      chk("f1_busy", {31'd0, bus.BUSY}, {31'd0, c <= 16});
      chk("f1_done", {31'd0, bus.DONE}, {31'd0, c == 17});
      chk("f1_others", {29'd0, bus.CCDUZ, bus.ATLC1H, bus.ATLF2H}, 32'd0);
    end

    // Priority queue: all four requests in one cycle
    exp_pend = '{4'b1110, 4'b1100, 4'b1000, 4'b0000};
    exp_len  = '{Z, 16, 16, 16};
    pulse(5'b01111);
    chk("pq_pend0", {28'd0, bus.PEND}, 32'hF);
    nruns = 0; cur = 0; last_done = -1; prev_busy = 1'b0;
    plog = '{default: -1};
    rlen = '{default: -1};
    for (int c = 1; c <= 60; c++) begin
      step();
      if (bus.BUSY && !prev_busy && nruns < 4) begin
        plog[nruns] = int'(bus.PEND);
        nruns++;
        cur = 0;
      end
      if (bus.BUSY) cur++;
      if (bus.DONE) begin
        if (nruns > 0) rlen[nruns-1] = cur;
        last_done = c;
      end
      prev_busy = bus.BUSY;
    end
    chk("pq_runs", nruns, 4);
    for (int i = 0; i < 4; i++) begin
      chk("pq_pend_at_grant", plog[i], exp_pend[i]);
      chk("pq_run_len", rlen[i], exp_len[i]);
    end
    chk("pq_last_done", last_done, 55);

    // Zero request queued during a coarse run
    pulse(5'b00010);
    for (int c = 1; c <= 22; c++) begin
      if (c == 6) drive(5'b00001);
      step();
      drive(5'd0);
      if (c == 17) begin
        chk("qb_done", {31'd0, bus.DONE}, 32'd1);
        chk("qb_pend", {28'd0, bus.PEND}, 32'd1);
      end
      if (c >= 17 && c <= 21)
        chk("qb_ccduz", {31'd0, bus.CCDUZ}, {31'd0, c >= 18 && c <= 20});
      if (c == 21) chk("qb_zero_done", {31'd0, bus.DONE}, 32'd1);
    end

    // Abort table
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].in);
      step();
      drive(5'd0);
      chk("tbl", {22'd0, dut_vec()}, {22'd0, tbl[i].exp});
    end

    // Reset mid-FINE1 with PEND=0101
    pulse(5'b00100);
    repeat (3) step();
    pulse(5'b00101);
    chk("rst_pend_before", {28'd0, bus.PEND}, 32'h5);
    chk("rst_busy_before", {31'd0, bus.BUSY}, 32'd1);
    #2 rst = 1'b1;
    #1 chk("rst_async", {22'd0, dut_vec()}, 32'd0);
    model_reset();
    step();
    rst = 1'b0;
    nz = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (dut_vec() != 10'd0) nz++;
    end
    chk("rst_quiet", nz, 0);

    // Random requests, aborts and resets against the model
    for (int c = 0; c < 2500; c++) begin
      drive({$urandom_range(0, 79) == 0, $urandom_range(0, 11) == 0,
             $urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0,
             $urandom_range(0, 11) == 0});
      rst = ($urandom_range(0, 399) == 0);
      step();
      rst = 1'b0;
    end
    drive(5'd0);
    pulse(5'b10000);

    // Default parameters: 4 periods of 640 low / 640 high
    bus_d.F1REQ = 1'b1;
    step();
    bus_d.F1REQ = 1'b0;
    step();
    chk("def_grant_busy", {31'd0, bus_d.BUSY}, 32'd1);
    done_n = -1; rises = 0; first_rise = -1; prev_lvl = bus_d.ATLF1H;
    for (int n = 1; n <= 5200; n++) begin
      step();
      if (bus_d.ATLF1H && !prev_lvl) begin
        rises++;
        if (first_rise < 0) first_rise = n;
      end
      prev_lvl = bus_d.ATLF1H;
      if (bus_d.DONE && done_n < 0) done_n = n;
    end
    chk("def_first_rise", first_rise, 640);
    chk("def_rises", rises, 4);
    chk("def_done", done_n, 5120);
    chk("def_idle", {31'd0, bus_d.BUSY}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/test_level_sequencer.md
# test_level_sequencer

Sequences the CDU self-test and zeroing stimuli that feed the error-angle and coarse modules: zero command CCDUZ, coarse test level ATLC1H, and fine test levels ATLF1H / ATLF2H. Replaces the free-running simulation stand-in for ATLF1H and drives the currently undriven CCDUZ and ATLF2H. Accepts one-cycle requests from the mode logic, queues them, and grants them one at a time by fixed priority. At most one stimulus output is asserted at any time.

## Interface

Parameters:
- HALF_PERIOD, 640: CLOCKH cycles per half of a test-level square wave (625 µs at 1.024 MHz); legal range ≥ 2.
- N_CYCLES, 4: full square-wave periods per test run; legal range ≥ 1.
- ZERO_CYCLES, 16: CLOCKH cycles CCDUZ is held high; legal range ≥ 1.

Ports:
- CLOCKH  in  1  system clock, all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- ZREQ  in  1  zero request, one-cycle pulse.
- C1REQ  in  1  coarse test request, one-cycle pulse.
- F1REQ  in  1  fine-1 test request, one-cycle pulse.
- F2REQ  in  1  fine-2 test request, one-cycle pulse.
- ABORT  in  1  synchronous abort of the active run and the queue.
- CCDUZ  out  1  zero command to the counters.
- ATLC1H  out  1  coarse test level.
- ATLF1H  out  1  fine-1 test level.
- ATLF2H  out  1  fine-2 test level.
- BUSY  out  1  high in any non-IDLE state.
- DONE  out  1  one-cycle pulse on normal completion of a run.
- PEND  out  4  pending bits {F2, F1, C1, Z}.

## Operation

- States: IDLE, ZERO, COARSE, FINE1, FINE2.
- Requests: a request high at an edge sets its PEND bit. Setting a bit that is already set has no further effect. A request for the kind currently running is queued and re-runs after completion.
- Grant: in IDLE, if PEND ≠ 0, the next edge enters the state for the highest-priority pending bit and clears that bit. Priority order: Z, then C1, then F1, then F2.
- ZERO run:
  - CCDUZ is high for exactly ZERO_CYCLES cycles.
  - On the last cycle, the state returns to IDLE and DONE pulses.
- Test run (COARSE, FINE1 or FINE2):
  - The selected level is low for HALF_PERIOD cycles, then high for HALF_PERIOD cycles.
  - This repeats N_CYCLES times, for 2·HALF_PERIOD·N_CYCLES cycles in total.
  - After the final high half, the state returns to IDLE and DONE pulses.
- Outputs are registered and one-hot-or-zero. Non-selected levels are held low.
- Counters:
  - Half-period counter: width clog2(HALF_PERIOD). Counts 0 … HALF_PERIOD−1, then wraps and toggles the phase.
  - Period counter: width clog2(N_CYCLES+1). Increments on the high→low wrap.
  - Zero counter: width clog2(ZERO_CYCLES+1).
  - No counter may overflow for any legal parameter value.
- ABORT:
  - Next edge: state goes to IDLE, all outputs go low, PEND clears, DONE is not pulsed.
  - ABORT wins over a simultaneous request; that request is dropped.
- rst: at any time, including mid-run, forces IDLE and clears every counter and PEND.

## Timing

- Reset values: CCDUZ=0, ATLC1H=0, ATLF1H=0, ATLF2H=0, BUSY=0, DONE=0, PEND=0000.
- Latency:
  - Request at edge k sets PEND at k.
  - If the block is IDLE, the grant occurs at edge k+1; the stimulus output and BUSY are visible after k+1.
- Back-to-back runs: DONE and IDLE occupy one cycle; the next grant occurs on the following edge. There is at least one IDLE cycle between any two runs.
- A request on the same edge as DONE is set in PEND and granted one cycle later.
- When several requests arrive in one cycle, all are queued and served in priority order, each separated by one IDLE cycle.
- A test level always begins low, so its first rising edge is HALF_PERIOD cycles after the grant.
- BUSY is high from the grant edge through the last stimulus cycle and is low in the DONE cycle.

## Test plan

All scenarios use HALF_PERIOD=4, N_CYCLES=2, ZERO_CYCLES=3 unless stated.

- Reset: assert rst mid-FINE1 with PEND=0101 → all outputs 0 and PEND=0000 immediately; after release, IDLE with no activity for 20 cycles.
- Single fine-1 run: F1REQ pulse → ATLF1H pattern 0000 1111 0000 1111 starting 1 cycle after the request; DONE high on cycle 17; BUSY high for cycles 1–16; other outputs stay 0.
- Priority queue: F2REQ, F1REQ, C1REQ and ZREQ in the same cycle → runs in order ZERO (3 cycles), COARSE (16), FINE1 (16), FINE2 (16), each followed by a DONE pulse and one IDLE cycle; PEND steps 1111→1110→1100→1000→0000.
- Queue while busy: ZREQ during cycle 5 of a COARSE run → COARSE completes unchanged; CCDUZ high for 3 cycles starting 1 cycle after the COARSE DONE.
- Abort: ABORT at cycle 6 of FINE2, coincident with F1REQ → next edge all levels 0, BUSY=0, PEND=0000, no DONE pulse, no FINE1 run follows.
- Default parameters: a single F1REQ → 4 periods of 640 low / 640 high; DONE exactly 5120 cycles after the grant.
